// File: rtl/rca_pipe_pkg.sv
// Shared constants and tag type for the pipelined ripple-carry adder scheduler.
package rca_pipe_pkg;

    localparam int unsigned RCA_WIDTH     = 8;
    localparam int unsigned RCA_ADDER_LAT = 9;

    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Sized for the largest supported requester count (8).
    localparam int unsigned TAG_ID_W = id_w(8);

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rca_pipe_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter
    import rca_pipe_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PW      = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      gnt_id,
    output logic [PW-1:0]      next_ptr
);

    always_comb begin
        int unsigned idx;
        logic        found;
        gnt      = '0;
        gnt_id   = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = PW'(idx);
                next_ptr = PW'((idx + 1) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/rca_pipe_sched.sv
// Round-robin scheduler sharing one external pipelined adder; a shadow tag
// pipeline returns each result to its requester as a one-hot pulse.
module rca_pipe_sched
    import rca_pipe_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = RCA_WIDTH,
    parameter int unsigned ADDER_LAT = RCA_ADDER_LAT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    input  logic                     issue_hold,
    output logic [WIDTH-1:0]         adder_a,
    output logic [WIDTH-1:0]         adder_b,
    output logic                     adder_cin,
    input  logic [WIDTH-1:0]         adder_sum,
    input  logic                     adder_cout,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_sum,
    output logic                     resp_cout,
    output logic                     busy
);

    localparam int unsigned PW = id_w(NUM_REQ);

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gnt_id;
    logic [PW-1:0]      next_ptr;
    logic               xfer;

    // Stage 0 runs alongside the operand registers; stages 1..ADDER_LAT track
    // the adder's internal registers, so the tail lines up with adder_sum.
    tag_t tags [ADDER_LAT+1];

    assign arb_req = (issue_hold || !rst_n) ? '0 : req_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (arb_req),
        .ptr      (ptr),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .next_ptr (next_ptr)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            adder_a   <= '0;
            adder_b   <= '0;
            adder_cin <= 1'b0;
        end else if (xfer) begin
            ptr       <= next_ptr;
            adder_a   <= req_a[int'(gnt_id)*WIDTH +: WIDTH];
            adder_b   <= req_b[int'(gnt_id)*WIDTH +: WIDTH];
            adder_cin <= req_cin[gnt_id];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= ADDER_LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0] <= '{valid: xfer, id: TAG_ID_W'(gnt_id)};
            for (int unsigned i = 1; i <= ADDER_LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= '0;
            resp_sum   <= '0;
            resp_cout  <= 1'b0;
        end else if (tags[ADDER_LAT].valid) begin
            resp_valid <= NUM_REQ'(1) << tags[ADDER_LAT].id;
            resp_sum   <= adder_sum;
            resp_cout  <= adder_cout;
        end else begin
            resp_valid <= '0;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i <= ADDER_LAT; i++) begin
            busy = busy | tags[i].valid;
        end
    end

endmodule

// File: tb/tb_rca_pipe_sched.sv
// Directed bench for rca_pipe_sched with a behavioural 9-stage adder attached.
`timescale 1ns/1ps
module tb_rca_pipe_sched;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LAT = 9;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_cin;
    logic           issue_hold;
    logic [W-1:0]   adder_a, adder_b, adder_sum;
    logic           adder_cin, adder_cout;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_sum;
    logic           resp_cout;
    logic           busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rca_pipe_sched #(.NUM_REQ(N), .WIDTH(W), .ADDER_LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .issue_hold (issue_hold),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
        .resp_valid (resp_valid),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .busy       (busy)
    );

    // Behavioural adder: LAT register stages, no reset, no stall.
    logic [W:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= 9'(adder_a) + 9'(adder_b) + 9'(adder_cin);
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign adder_sum  = apipe[LAT-1][W-1:0];
    assign adder_cout = apipe[LAT-1][W];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor
    int         mon_id  [$];
    logic [W:0] mon_sum [$];
    int         mon_cyc [$];
    initial forever begin
        @(posedge clk);
        #1;
        if (resp_valid !== '0) begin
            int id;
            id = -1;
            for (int i = 0; i < N; i++) if (resp_valid[i]) id = i;
            chk("resp_onehot", 32'($countones(resp_valid)), 32'd1);
            mon_id.push_back(id);
            mon_sum.push_back({resp_cout, resp_sum});
            mon_cyc.push_back(cyc);
        end
    end

    int         e_id  [$];
    logic [W:0] e_sum [$];
    logic [W-1:0] ra [N];
    logic [W-1:0] rb [N];
    logic         rc [N];

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        ra[i] = a; rb[i] = b; rc[i] = c;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        mon_id.delete(); mon_sum.delete(); mon_cyc.delete();
        e_id.delete(); e_sum.delete();
    endtask

    task automatic cmp_q(input string tag, input int gap);
        chk({tag, "_count"}, 32'(mon_id.size()), 32'(e_id.size()));
        for (int i = 0; i < e_id.size() && i < mon_id.size(); i++) begin
            chk({tag, "_id"}, 32'(mon_id[i]), 32'(e_id[i]));
            chk({tag, "_sum"}, 32'(mon_sum[i]), 32'(e_sum[i]));
            if (gap > 0 && i > 0)
                chk({tag, "_gap"}, 32'(mon_cyc[i] - mon_cyc[i-1]), 32'(gap));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, mptr;
        logic [N-1:0] rv, exp_rdy;
        req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; issue_hold = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, 8'h00, 8'h00, 1'b0);

        // Reset values
        #12;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_adder_a", 32'(adder_a), 32'h0);
        chk("rst_resp", 32'({resp_cout, resp_sum}), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single op from requester 2: FF + 01 + 1 = 1_01, 10 cycles later
        clear_q();
        set_op(2, 8'hFF, 8'h01, 1'b1);
        req_valid = 4'b0100;
        #1 chk("t1_ready", 32'(req_ready), 32'h4);
        tick();
        chk("t1_adder_a", 32'(adder_a), 32'hFF);
        chk("t1_adder_b", 32'(adder_b), 32'h01);
        chk("t1_adder_cin", 32'(adder_cin), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        req_valid = '0;
        for (int c = 1; c <= 9; c++) tick();
        chk("t1_early", 32'(resp_valid), 32'h0);
        tick();
        chk("t1_resp_valid", 32'(resp_valid), 32'h4);
        chk("t1_resp_sum", 32'(resp_sum), 32'h01);
        chk("t1_resp_cout", 32'(resp_cout), 32'h1);
        tick();
        chk("t1_pulse_end", 32'(resp_valid), 32'h0);

        // All four valid: pointer sits at 3 after the previous grant
        clear_q();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) set_op(i, 8'(16*c + 3*i), 8'(8'hF0 + i), 1'(i & 1));
            req_valid = 4'hF;
            #1;
            g = (3 + c) % N;
            chk("t2_ready", 32'(req_ready), 32'(1 << g));
            e_id.push_back(g);
            e_sum.push_back(9'(ra[g]) + 9'(rb[g]) + 9'(rc[g]));
            tick();
        end
        req_valid = '0;
        repeat (12) tick();
        cmp_q("t2", 1);

        // Alternate-cycle requests from requester 1
        clear_q();
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0) begin
                set_op(1, 8'(8'h40 + c), 8'(8'hC0 - c), 1'(c >> 1));
                req_valid = 4'b0010;
                #1 chk("t3_ready", 32'(req_ready), 32'h2);
                e_id.push_back(1);
                e_sum.push_back(9'(ra[1]) + 9'(rb[1]) + 9'(rc[1]));
            end else begin
                req_valid = '0;
            end
            tick();
        end
        req_valid = '0;
        repeat (8) tick();
        chk("t3_busy_last", 32'(busy), 32'h1);
        tick();
        chk("t3_busy_drop", 32'(busy), 32'h0);
        repeat (3) tick();
        cmp_q("t3", 2);

        // Three ops from requester 0, then hold with everyone valid
        clear_q();
        for (int c = 0; c < 3; c++) begin
            set_op(0, 8'(8'h80 + c), 8'h7F, 1'b1);
            req_valid = 4'b0001;
            #1 chk("t4_ready", 32'(req_ready), 32'h1);
            e_id.push_back(0);
            e_sum.push_back(9'(ra[0]) + 9'(rb[0]) + 9'(rc[0]));
            tick();
        end
        req_valid = 4'hF;
        issue_hold = 1'b1;
        for (int c = 0; c < 14; c++) begin
            #1 chk("t4_hold_ready", 32'(req_ready), 32'h0);
            tick();
        end
        chk("t4_busy", 32'(busy), 32'h0);
        cmp_q("t4", 1);
        issue_hold = 1'b0;
        req_valid = '0;

        // Reset with five ops in flight
        clear_q();
        req_valid = 4'hF;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_ready", 32'(req_ready), 32'h0);
        chk("t5_resp_valid", 32'(resp_valid), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_adder_a", 32'(adder_a), 32'h0);
        chk("t5_resp", 32'({resp_cout, resp_sum}), 32'h0);
        repeat (3) @(posedge clk);
        req_valid = '0;
        @(negedge clk) rst_n = 1'b1;
        repeat (14) tick();
        chk("t5_no_resp", 32'(mon_id.size()), 32'h0);
        req_valid = 4'hF;
        #1 chk("t5_ptr_restart", 32'(req_ready), 32'h1);
        req_valid = '0;
        tick();

        // Random traffic against a round-robin reference
        clear_q();
        mptr = 0;
        for (int c = 0; c < 3000; c++) begin
            rv = 4'($urandom_range(0, 15));
            issue_hold = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++)
                set_op(i, 8'($urandom), 8'($urandom), 1'($urandom));
            req_valid = rv;
            #1;
            g = -1;
            for (int off = 0; off < N; off++)
                if (g < 0 && rv[(mptr + off) % N]) g = (mptr + off) % N;
            if (issue_hold) g = -1;
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'h0;
            chk("t6_ready", 32'(req_ready), 32'(exp_rdy));
            if (g >= 0) begin
                e_id.push_back(g);
                e_sum.push_back(9'(ra[g]) + 9'(rb[g]) + 9'(rc[g]));
                mptr = (g + 1) % N;
            end
            tick();
        end
        req_valid = '0;
        issue_hold = 1'b0;
        repeat (12) tick();
        cmp_q("t6", 0);
        chk("t6_busy", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
